accel_sampler: RTL
==================

Name: accel_sampler

Overview:
Command sequencer that sits directly upstream of the SPI master and drives its enable/rw/address/value request interface. After reset it configures the 3-axis accelerometer with three register writes. It then issues a periodic 6-byte burst read of the data registers. It unpacks the master's 56-bit receive buffer into signed X/Y/Z samples with a one-cycle valid strobe for downstream vibration processing.

Parameters:
STARTUP_CYCLES, 24000, clk cycles to wait after reset before the first SPI transaction (sensor power-up).
SAMPLE_PERIOD, 120000, clk cycles between read launches (100 Hz at 12 MHz); legal range 64 to 2^24-1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = keep sampling after configuration; 0 = stop issuing reads
spi_enable  out  1  transaction request to SPI master; level, held until spi_sync seen
spi_rw  out  1  1 = read (burst), 0 = write
spi_address  out  6  sensor register address
spi_value  out  8  write data (don't-care on reads, driven 0)
spi_buffer  in  56  SPI master receive buffer
spi_sync  in  1  SPI master done flag (high while master is in its finished state)
x, y, z  out  16 each  signed samples, two's complement
sample_valid  out  1  one-cycle pulse when x/y/z update
init_done  out  1  high once all configuration writes have completed
overrun  out  1  sticky: a sample tick occurred while a read was still in flight

Behaviour:
- Reset (synchronous, active-high, on clk) values: spi_enable=0, spi_rw=0, spi_address=0, spi_value=0, x=y=z=0, sample_valid=0, init_done=0, overrun=0, state=STARTUP, all counters 0. Reset mid-transaction drops spi_enable immediately; the master is reset by the same signal.
- Configuration table, in order (address, value): (0x31, 0x0B) full resolution; (0x2C, 0x0A) 100 Hz rate; (0x2D, 0x08) measure mode. All use spi_rw=0.
- Read command: spi_rw=1, spi_address=0x32, spi_value=0.
- Handshake, per transaction:
  - Drive rw/address/value and raise spi_enable in the same cycle; hold all stable while enable is high.
  - On the first cycle spi_sync=1, drop spi_enable in the next cycle.
  - Launch the next transaction only after spi_sync is observed 0.
  - Never raise spi_enable while spi_sync=1.
- States:
  - STARTUP: count STARTUP_CYCLES, then go to CFG_REQ.
  - CFG_REQ: enable high with table entry idx; on spi_sync go to CFG_REL.
  - CFG_REL: enable low; when spi_sync=0, increment idx. If idx was 2, set init_done=1 and go to IDLE; otherwise go to CFG_REQ.
  - IDLE: wait for sample tick with run=1, then go to RD_REQ.
  - RD_REQ: enable high, read command; on spi_sync capture the buffer and go to RD_REL.
  - RD_REL: enable low; when spi_sync=0, go to IDLE.
- Sample timer:
  - Free-running counter starts at 0 when init_done rises.
  - Tick fires when the count reaches SAMPLE_PERIOD-1, then the count wraps to 0. Timer runs regardless of run.
  - A tick is consumed only in IDLE with run=1; ticks while run=0 are discarded and do not set overrun.
  - A tick while in RD_REQ or RD_REL with run=1 sets overrun (sticky until reset) and is dropped; no queuing.
- Capture, on the spi_sync cycle in RD_REQ:
  - Bytes are taken from spi_buffer[47:0]: B0=[47:40], B1=[39:32], B2=[31:24], B3=[23:16], B4=[15:8], B5=[7:0].
  - x={B1,B0}, y={B3,B2}, z={B5,B4}.
  - x/y/z register the next cycle, with sample_valid=1 for exactly that one cycle.
- run falling mid-read: the read completes and its sample is delivered; no further reads are issued.
- Latency: tick to spi_enable high = 1 cycle when in IDLE.

Test Plan:
- Reset, STARTUP_CYCLES=16, SAMPLE_PERIOD=200, SPI master model → first spi_enable at cycle 16 after reset release; three writes observed: 0x31/0x0B, 0x2C/0x0A, 0x2D/0x08; init_done rises after the third spi_sync falls.
- run=1, model returns buffer bytes 0x34,0x12,0xFE,0xFF,0x00,0x01 → x=0x1234, y=-2, z=0x0100; sample_valid is a single pulse; next read launches 200 cycles after the previous one.
- Handshake check → spi_enable drops the cycle after spi_sync rises and is never high while spi_sync=1; address/rw stable for the whole enable window.
- Model delays spi_sync beyond SAMPLE_PERIOD → overrun=1 and stays set; exactly one sample is delivered for that read; the next read launches on a later tick.
- run=0 during a read → that sample is delivered, no further spi_enable, overrun stays 0; run=1 again → reads resume on the next tick.
- Assert reset during a read (enable high) → all outputs return to reset values the next cycle and the configuration sequence restarts from STARTUP.

Source files
------------

// File: rtl/accel_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : accel_sampler_if
// Description : Request/response bundle between the accelerometer command
//               sequencer and the SPI master. The sequencer is the master
//               side of this bundle; the SPI master is the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface accel_sampler_if;
    logic        spi_enable;
    logic        spi_rw;
    logic [5:0]  spi_address;
    logic [7:0]  spi_value;
    logic [55:0] spi_buffer;
    logic        spi_sync;

    modport master (
        output spi_enable,
        output spi_rw,
        output spi_address,
        output spi_value,
        input  spi_buffer,
        input  spi_sync
    );

    modport slave (
        input  spi_enable,
        input  spi_rw,
        input  spi_address,
        input  spi_value,
        output spi_buffer,
        output spi_sync
    );
endinterface
`default_nettype wire

// File: rtl/accel_sampler.sv
`default_nettype none
// ============================================================================
// Module      : accel_sampler
// Description : Command sequencer in front of the SPI master. Configures a
//               3-axis accelerometer with three register writes after a
//               power-up delay, then launches periodic 6-byte burst reads and
//               unpacks the receive buffer into signed X/Y/Z samples.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_sampler #(
    parameter int STARTUP_CYCLES = 24000,   // must be >= 1
    parameter int SAMPLE_PERIOD  = 120000   // 64 .. 2^24-1
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 run,
    accel_sampler_if.master     spi,
    output logic signed [15:0]  x,
    output logic signed [15:0]  y,
    output logic signed [15:0]  z,
    output logic                sample_valid,
    output logic                init_done,
    output logic                overrun
);

    localparam int c_SU_W  = $clog2(STARTUP_CYCLES + 1);
    localparam int c_TMR_W = $clog2(SAMPLE_PERIOD);

    localparam logic [c_SU_W-1:0]  c_SU_LAST  = c_SU_W'(STARTUP_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SAMPLE_PERIOD - 1);

    localparam logic [5:0] c_RD_ADDR = 6'h32;

    localparam logic [2:0] c_ST_STARTUP = 3'd0;
    localparam logic [2:0] c_ST_CFG_REQ = 3'd1;
    localparam logic [2:0] c_ST_CFG_REL = 3'd2;
    localparam logic [2:0] c_ST_IDLE    = 3'd3;
    localparam logic [2:0] c_ST_RD_REQ  = 3'd4;
    localparam logic [2:0] c_ST_RD_REL  = 3'd5;

    logic [2:0]         r_state;
    logic [c_SU_W-1:0]  r_su_cnt;
    logic [c_TMR_W-1:0] r_timer;
    logic [1:0]         r_idx;
    logic               w_tick;

    // Top byte of the receive buffer (command slot) carries no sample data.
    wire w_unused_buf = &{1'b0, spi.spi_buffer[55:48]};

    // Configuration table: {address, value}.
    function automatic logic [13:0] f_cfg_entry(input logic [1:0] idx);
        case (idx)
            2'd0:    return {6'h31, 8'h0B};   // full resolution
            2'd1:    return {6'h2C, 8'h0A};   // 100 Hz output rate
            default: return {6'h2D, 8'h08};   // measurement mode
        endcase
    endfunction

    assign w_tick = init_done && (r_timer == c_TMR_LAST);

    // Free-running sample timer, held at zero until configuration finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (!init_done || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Sequencer: startup delay, config writes, then tick-driven burst reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_STARTUP;
            r_su_cnt        <= '0;
            r_idx           <= '0;
            spi.spi_enable  <= 1'b0;
            spi.spi_rw      <= 1'b0;
            spi.spi_address <= '0;
            spi.spi_value   <= '0;
            x               <= '0;
            y               <= '0;
            z               <= '0;
            sample_valid    <= 1'b0;
            init_done       <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                c_ST_STARTUP: begin
                    if (r_su_cnt == c_SU_LAST) begin
                        r_state        <= c_ST_CFG_REQ;
                        spi.spi_enable <= 1'b1;
                        spi.spi_rw     <= 1'b0;
                        {spi.spi_address, spi.spi_value} <= f_cfg_entry(r_idx);
                    end else begin
                        r_su_cnt <= r_su_cnt + 1'b1;
                    end
                end
                c_ST_CFG_REQ: begin
                    if (spi.spi_sync) begin
                        spi.spi_enable <= 1'b0;
                        r_state        <= c_ST_CFG_REL;
                    end
                end
                c_ST_CFG_REL: begin
                    // Wait for the master to leave its done state before
                    // issuing the next write.
                    if (!spi.spi_sync) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd2) begin
                            init_done <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_state        <= c_ST_CFG_REQ;
                            spi.spi_enable <= 1'b1;
                            {spi.spi_address, spi.spi_value} <= f_cfg_entry(r_idx + 2'd1);
                        end
                    end
                end
                c_ST_IDLE: begin
                    if (w_tick && run) begin
                        r_state         <= c_ST_RD_REQ;
                        spi.spi_enable  <= 1'b1;
                        spi.spi_rw      <= 1'b1;
                        spi.spi_address <= c_RD_ADDR;
                        spi.spi_value   <= '0;
                    end
                end
                c_ST_RD_REQ: begin
                    if (w_tick && run) overrun <= 1'b1;
                    if (spi.spi_sync) begin
                        spi.spi_enable <= 1'b0;
                        x              <= {spi.spi_buffer[39:32], spi.spi_buffer[47:40]};
                        y              <= {spi.spi_buffer[23:16], spi.spi_buffer[31:24]};
                        z              <= {spi.spi_buffer[7:0],   spi.spi_buffer[15:8]};
                        sample_valid   <= 1'b1;
                        r_state        <= c_ST_RD_REL;
                    end
                end
                c_ST_RD_REL: begin
                    if (w_tick && run) overrun <= 1'b1;
                    if (!spi.spi_sync) r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state        <= c_ST_STARTUP;
                    spi.spi_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
